// File: rtl/shreg_pkg.sv
// Shared types and helpers for the multi-mode shift register.
//   shreg_mode_e : per-edge operation select
//   fill_width() : bit width of a counter that must hold 0..depth inclusive
package shreg_pkg;

    typedef enum logic [1:0] {
        SHIFT_FWD = 2'b00,
        SHIFT_REV = 2'b01,
        ROTATE    = 2'b10,
        LOAD      = 2'b11
    } shreg_mode_e;

    function automatic int unsigned fill_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/shreg_multimode_if.sv
// Control/data bundle for shreg_multimode.
//   master : drives en, mode, sclr, ser_in, par_in; observes the outputs
//   slave  : the shift register itself
//   par_in/par_out pack stage i at [i*WIDTH +: WIDTH]
interface shreg_multimode_if
    import shreg_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned FillW = fill_width(DEPTH);

    logic                     en;
    shreg_mode_e              mode;
    logic                     sclr;
    logic [WIDTH-1:0]         ser_in;
    logic [DEPTH*WIDTH-1:0]   par_in;
    logic [WIDTH-1:0]         ser_out_hi;
    logic [WIDTH-1:0]         ser_out_lo;
    logic [DEPTH*WIDTH-1:0]   par_out;
    logic [FillW-1:0]         fill;
    logic                     full;

    modport master (
        output en, mode, sclr, ser_in, par_in,
        input  ser_out_hi, ser_out_lo, par_out, fill, full
    );

    modport slave (
        input  en, mode, sclr, ser_in, par_in,
        output ser_out_hi, ser_out_lo, par_out, fill, full
    );

endinterface

// File: rtl/shreg_stage.sv
// One WIDTH-bit stage of the shift chain.
//   clk, rst_n      : clock, async active-low reset
//   sclr_i, en_i    : sync clear (highest priority), enable (hold when low)
//   mode_i          : operation for this edge
//   fwd_i           : value taken on SHIFT_FWD / ROTATE (lower neighbour or edge tap)
//   rev_i           : value taken on SHIFT_REV (upper neighbour or ser_in)
//   par_i           : value taken on LOAD
//   q_o             : registered stage contents
module shreg_stage
    import shreg_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclr_i,
    input  logic             en_i,
    input  shreg_mode_e      mode_i,
    input  logic [WIDTH-1:0] fwd_i,
    input  logic [WIDTH-1:0] rev_i,
    input  logic [WIDTH-1:0] par_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_d, q_q;

    always_comb begin
        q_d = q_q;
        if (sclr_i) begin
            q_d = '0;
        end else if (en_i) begin
            unique case (mode_i)
                SHIFT_FWD, ROTATE: q_d = fwd_i;
                SHIFT_REV:         q_d = rev_i;
                LOAD:              q_d = par_i;
                default:           q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/shreg_multimode.sv
// Multi-mode shift register: DEPTH stages of WIDTH bits with forward/reverse
// shift, rotate, parallel load and sync clear, plus a saturating fill counter.
//   clk, rst_n : clock, async active-low reset
//   bus        : shreg_multimode_if slave (controls, serial/parallel data,
//                ser_out_hi = stage DEPTH-1, ser_out_lo = stage 0, fill, full)
// All outputs come straight from registers.
module shreg_multimode
    import shreg_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    shreg_multimode_if.slave bus
);

    localparam int unsigned      FillW   = fill_width(DEPTH);
    localparam logic [FillW-1:0] FillMax = FillW'(DEPTH);

    logic [WIDTH-1:0] stage_q [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] fwd, rev;

        // Stage 0 is fed from ser_in when shifting but from the far end when rotating.
        if (i == 0) begin : g_fwd_edge
            assign fwd = (bus.mode == ROTATE) ? stage_q[DEPTH-1] : bus.ser_in;
        end else begin : g_fwd_mid
            assign fwd = stage_q[i-1];
        end

        if (i == DEPTH - 1) begin : g_rev_edge
            assign rev = bus.ser_in;
        end else begin : g_rev_mid
            assign rev = stage_q[i+1];
        end

        shreg_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .sclr_i (bus.sclr),
            .en_i   (bus.en),
            .mode_i (bus.mode),
            .fwd_i  (fwd),
            .rev_i  (rev),
            .par_i  (bus.par_in[i*WIDTH +: WIDTH]),
            .q_o    (stage_q[i])
        );

        assign bus.par_out[i*WIDTH +: WIDTH] = stage_q[i];
    end

    // Fill counts enabled shifts in either direction; rotate keeps it, load fills it.
    logic [FillW-1:0] fill_d, fill_q;

    always_comb begin
        fill_d = fill_q;
        if (bus.sclr) begin
            fill_d = '0;
        end else if (bus.en) begin
            unique case (bus.mode)
                SHIFT_FWD, SHIFT_REV: begin
                    if (fill_q != FillMax) begin
                        fill_d = fill_q + FillW'(1);
                    end
                end
                LOAD:    fill_d = FillMax;
                ROTATE:  fill_d = fill_q;
                default: fill_d = fill_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q <= '0;
        end else begin
            fill_q <= fill_d;
        end
    end

    assign bus.ser_out_hi = stage_q[DEPTH-1];
    assign bus.ser_out_lo = stage_q[0];
    assign bus.fill       = fill_q;
    assign bus.full       = (fill_q == FillMax);

endmodule

// File: tb/tb_shreg_multimode.sv
// Bench for shreg_multimode: instance A is 1x16, instance B is 8x4.
// The driver pushes hand-computed expectations after each edge; a monitor on
// the falling edge pops and compares them.
module tb_shreg_multimode;
    import shreg_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shreg_multimode_if #(.WIDTH(1), .DEPTH(16)) a_if ();
    shreg_multimode_if #(.WIDTH(8), .DEPTH(4))  b_if ();

    shreg_multimode #(.WIDTH(1), .DEPTH(16)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if.slave)
    );

    shreg_multimode #(.WIDTH(8), .DEPTH(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if.slave)
    );

    // mask bits: 0 par_out, 1 ser_out_hi, 2 ser_out_lo, 3 fill, 4 full
    typedef struct {
        string       tag;
        bit          is_b;
        logic [4:0]  mask;
        logic [31:0] par;
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [4:0]  fill;
        logic        full;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic cmp(input string tag, input string field, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %0h, expected %0h", tag, field, act, exp);
        end
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            logic [31:0] a_par, a_hi, a_lo, a_fill, a_full;
            mon_e = sb.pop_front();
            if (mon_e.is_b) begin
                a_par  = b_if.par_out;
                a_hi   = {24'd0, b_if.ser_out_hi};
                a_lo   = {24'd0, b_if.ser_out_lo};
                a_fill = {29'd0, b_if.fill};
                a_full = {31'd0, b_if.full};
            end else begin
                a_par  = {16'd0, a_if.par_out};
                a_hi   = {31'd0, a_if.ser_out_hi};
                a_lo   = {31'd0, a_if.ser_out_lo};
                a_fill = {27'd0, a_if.fill};
                a_full = {31'd0, a_if.full};
            end
            if (mon_e.mask[0]) cmp(mon_e.tag, "par_out", a_par, mon_e.par);
            if (mon_e.mask[1]) cmp(mon_e.tag, "ser_out_hi", a_hi, {24'd0, mon_e.hi});
            if (mon_e.mask[2]) cmp(mon_e.tag, "ser_out_lo", a_lo, {24'd0, mon_e.lo});
            if (mon_e.mask[3]) cmp(mon_e.tag, "fill", a_fill, {27'd0, mon_e.fill});
            if (mon_e.mask[4]) cmp(mon_e.tag, "full", a_full, {31'd0, mon_e.full});
        end
    end

    task automatic push(input string tag, input bit is_b, input logic [4:0] mask,
                        input logic [31:0] par, input logic [7:0] hi, input logic [7:0] lo,
                        input logic [4:0] fill, input logic full);
        exp_t e;
        e.tag  = tag;
        e.is_b = is_b;
        e.mask = mask;
        e.par  = par;
        e.hi   = hi;
        e.lo   = lo;
        e.fill = fill;
        e.full = full;
        sb.push_back(e);
    endtask

    task automatic drive_a(input bit en, input shreg_mode_e m, input bit sclr,
                           input logic s, input logic [15:0] p);
        a_if.en     = en;
        a_if.mode   = m;
        a_if.sclr   = sclr;
        a_if.ser_in = s;
        a_if.par_in = p;
    endtask

    task automatic drive_b(input bit en, input shreg_mode_e m, input bit sclr,
                           input logic [7:0] s, input logic [31:0] p);
        b_if.en     = en;
        b_if.mode   = m;
        b_if.sclr   = sclr;
        b_if.ser_in = s;
        b_if.par_in = p;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected end before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] seq;
        logic [31:0] rot [4];
        seq = 16'hB2E2;  // s0..s15 = 1,0,1,1,0,0,1,0,1,1,1,0,0,0,1,0 (MSB first)
        rot[0] = 32'h33221144;
        rot[1] = 32'h22114433;
        rot[2] = 32'h11443322;
        rot[3] = 32'h44332211;

        drive_a(1'b0, SHIFT_FWD, 1'b0, 1'b0, 16'h0);
        drive_b(1'b0, SHIFT_FWD, 1'b0, 8'h0, 32'h0);
        #2;
        push("a_reset", 1'b0, 5'h1F, 32'h0, 8'h0, 8'h0, 5'd0, 1'b0);
        push("b_reset", 1'b1, 5'h1F, 32'h0, 8'h0, 8'h0, 5'd0, 1'b0);
        #10;
        rst_n = 1'b1;

        // A: 16 forward shifts of the reference pattern.
        for (int k = 0; k < 16; k++) begin
            drive_a(1'b1, SHIFT_FWD, 1'b0, seq[15-k], 16'h0);
            step();
            push("a_fwd", 1'b0, (k == 15) ? 5'h1F : 5'h1E, {16'd0, seq},
                 (k == 15) ? 8'h1 : 8'h0, {7'd0, seq[15-k]}, 5'(k + 1), (k == 15));
        end
        drive_a(1'b1, SHIFT_FWD, 1'b0, 1'b1, 16'h0);
        step();
        push("a_fwd_sat", 1'b0, 5'h1F, 32'h000065C5, 8'h0, 8'h1, 5'd16, 1'b1);

        drive_a(1'b1, LOAD, 1'b1, 1'b1, 16'hFFFF);
        step();
        push("a_sclr_load", 1'b0, 5'h1F, 32'h0, 8'h0, 8'h0, 5'd0, 1'b0);

        // A: one marker bit, then 3 disabled cycles, then 15 more shifts.
        drive_a(1'b1, SHIFT_FWD, 1'b0, 1'b1, 16'h0);
        step();
        push("a_mark", 1'b0, 5'h1F, 32'h1, 8'h0, 8'h1, 5'd1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            drive_a(1'b0, ROTATE, 1'b0, 1'b1, 16'hFFFF);
            step();
            push("a_hold", 1'b0, 5'h1F, 32'h1, 8'h0, 8'h1, 5'd1, 1'b0);
        end
        for (int n = 2; n <= 16; n++) begin
            drive_a(1'b1, SHIFT_FWD, 1'b0, 1'b0, 16'h0);
            step();
            push("a_stretch", 1'b0, 5'h1F, 32'h1 << (n - 1), (n == 16) ? 8'h1 : 8'h0,
                 8'h0, 5'(n), (n == 16));
        end
        drive_a(1'b0, SHIFT_FWD, 1'b0, 1'b0, 16'h0);

        // B: load then four rotates.
        drive_b(1'b1, LOAD, 1'b0, 8'hEE, 32'h44332211);
        step();
        push("b_load", 1'b1, 5'h1F, 32'h44332211, 8'h44, 8'h11, 5'd4, 1'b1);
        for (int k = 0; k < 4; k++) begin
            drive_b(1'b1, ROTATE, 1'b0, 8'hEE, 32'h0);
            step();
            push("b_rot", 1'b1, 5'h1F, rot[k], rot[k][31:24], rot[k][7:0], 5'd4, 1'b1);
        end

        drive_b(1'b1, ROTATE, 1'b1, 8'h0, 32'h0);
        step();
        push("b_clr", 1'b1, 5'h1F, 32'h0, 8'h0, 8'h0, 5'd0, 1'b0);

        // B: reverse shifts; the first sample reaches ser_out_lo after 4 edges.
        drive_b(1'b1, SHIFT_REV, 1'b0, 8'hA5, 32'h0);
        step();
        push("b_rev1", 1'b1, 5'h1F, 32'hA5000000, 8'hA5, 8'h00, 5'd1, 1'b0);
        drive_b(1'b1, SHIFT_REV, 1'b0, 8'h01, 32'h0);
        step();
        push("b_rev2", 1'b1, 5'h1F, 32'h01A50000, 8'h01, 8'h00, 5'd2, 1'b0);
        drive_b(1'b1, SHIFT_REV, 1'b0, 8'h02, 32'h0);
        step();
        push("b_rev3", 1'b1, 5'h1F, 32'h0201A500, 8'h02, 8'h00, 5'd3, 1'b0);
        drive_b(1'b1, SHIFT_REV, 1'b0, 8'h03, 32'h0);
        step();
        push("b_rev4", 1'b1, 5'h1F, 32'h030201A5, 8'h03, 8'hA5, 5'd4, 1'b1);

        drive_b(1'b1, LOAD, 1'b1, 8'h0, 32'hFFFFFFFF);
        step();
        push("b_sclr_load", 1'b1, 5'h1F, 32'h0, 8'h0, 8'h0, 5'd0, 1'b0);

        // B: direction changes keep counting.
        drive_b(1'b1, SHIFT_FWD, 1'b0, 8'h11, 32'h0);
        step();
        push("b_mix1", 1'b1, 5'h1F, 32'h00000011, 8'h00, 8'h11, 5'd1, 1'b0);
        drive_b(1'b1, SHIFT_REV, 1'b0, 8'h22, 32'h0);
        step();
        push("b_mix2", 1'b1, 5'h1F, 32'h22000000, 8'h22, 8'h00, 5'd2, 1'b0);
        drive_b(1'b1, SHIFT_FWD, 1'b0, 8'h33, 32'h0);
        step();
        push("b_mix3", 1'b1, 5'h1F, 32'h00000033, 8'h00, 8'h33, 5'd3, 1'b0);

        // Async reset mid-cycle after a shift edge.
        drive_b(1'b1, SHIFT_FWD, 1'b0, 8'h44, 32'h0);
        step();
        #1;
        rst_n = 1'b0;
        #1;
        push("b_async_rst", 1'b1, 5'h1F, 32'h0, 8'h0, 8'h0, 5'd0, 1'b0);
        push("a_async_rst", 1'b0, 5'h1F, 32'h0, 8'h0, 8'h0, 5'd0, 1'b0);
        drive_b(1'b1, SHIFT_FWD, 1'b0, 8'h77, 32'h0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        step();
        push("b_post_rst", 1'b1, 5'h1F, 32'h00000077, 8'h00, 8'h77, 5'd1, 1'b0);
        drive_b(1'b0, SHIFT_FWD, 1'b0, 8'h0, 32'h0);

        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shreg_multimode.md
# shreg_multimode

Parametrised multi-mode shift register: a DEPTH-stage chain of WIDTH-bit lanes with forward shift, reverse shift, rotate, parallel load and synchronous clear. It is the next-generation replacement for the fixed 16×1-bit enable-gated shift chain used in the placement test designs. It also adds a fill counter so downstream logic knows when serial data has reached the far end.

## Interface
- WIDTH, 1, bits per stage (lane width); legal ≥1
- DEPTH, 16, number of stages; legal ≥2
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  operation enable; when 0 all state holds
- mode  in  2  operation select (shreg_mode_e): 00 SHIFT_FWD, 01 SHIFT_REV, 10 ROTATE, 11 LOAD
- sclr  in  1  synchronous clear; overrides en and mode
- ser_in  in  WIDTH  serial lane input
- par_in  in  DEPTH*WIDTH  parallel load data; stage i = par_in[i*WIDTH +: WIDTH]
- ser_out_hi  out  WIDTH  stage DEPTH-1 contents (forward-direction output)
- ser_out_lo  out  WIDTH  stage 0 contents (reverse-direction output)
- par_out  out  DEPTH*WIDTH  all stages, same packing as par_in
- fill  out  $clog2(DEPTH+1)  count of valid stages, saturating at DEPTH
- full  out  1  fill == DEPTH

## Operation
- All outputs are registered or decoded directly from registers. There is no combinational path from any input to any output.
- Reset (rst_n=0, async assert): all stages 0, fill 0, full 0, ser_out_hi/lo 0, par_out 0.
- Priority per edge: sclr > en=0 (hold) > mode.
- sclr=1: all stages 0, fill 0, regardless of en.
- SHIFT_FWD: stage[0]←ser_in, stage[i]←stage[i-1]. Old stage[DEPTH-1] is discarded. fill←min(fill+1, DEPTH).
- SHIFT_REV: stage[DEPTH-1]←ser_in, stage[i]←stage[i+1]. Old stage[0] is discarded. fill←min(fill+1, DEPTH).
- ROTATE: stage[0]←stage[DEPTH-1], stage[i]←stage[i-1]. ser_in is ignored. fill is unchanged.
- LOAD: stage[i]←par_in slice i; fill←DEPTH.
- fill counts enabled shifts since the last clear or reset, in either direction, saturating at DEPTH. A direction change does not reset it.
- Mode can change on any cycle with no bubble. Each edge acts only on the mode sampled at that edge.

## Timing
- Single clock domain. Every operation completes in 1 cycle.
- Serial latency: ser_in sampled at a SHIFT_FWD edge appears on ser_out_hi after DEPTH enabled SHIFT_FWD edges. The same holds for SHIFT_REV and ser_out_lo.
- Partial disable: en=0 cycles stretch the latency but lose no data.
- full rises on the edge that takes fill from DEPTH-1 to DEPTH, and on any LOAD edge.
- full falls only on sclr or reset.
- Reset deasserts asynchronously; it must be externally synchronised to clk. The first active edge after release is a normal operation edge.
- Reset during a shift clears immediately. No partial update is retained.

## Structure
- Package shreg_pkg holds:
  - shreg_mode_e (2-bit enum SHIFT_FWD/SHIFT_REV/ROTATE/LOAD)
  - localparam FILL_W function helper ($clog2(DEPTH+1))
- Sub-module shreg_stage: one WIDTH-bit stage containing the 4:1 next-value mux (fwd neighbour, rev neighbour, par slice, hold) plus the flop with async reset and sclr. It is instantiated DEPTH times with a generate loop. Edge stages take ser_in or the wrap tap for their out-of-range neighbour.
- The fill counter and full decode live in the top module.

## Test plan
- Reset, then 16 SHIFT_FWD cycles with ser_in=1,0,1,1,… (WIDTH=1, DEPTH=16):
  - ser_out_hi shows the first bit on cycle 16
  - fill goes 1..16
  - full asserts after the 16th edge and fill stays 16 thereafter
- WIDTH=8, DEPTH=4: LOAD par_in=0x44332211, then 4 ROTATE:
  - par_out sequence 0x33221144, 0x22114433, 0x11443322, 0x44332211
  - fill stays 4 throughout
- SHIFT_REV with ser_in=0xA5 (WIDTH=8, DEPTH=4): ser_out_lo=0xA5 after 4 edges; ser_out_hi=0xA5 after 1 edge.
- en=0 for 3 cycles mid-stream: par_out and fill are frozen, and ser_out_hi appears 3 cycles later than with en held high.
- sclr=1 together with en=1 and mode=LOAD: stages 0, fill 0, full 0 on that edge.
- Async rst_n assertion mid-cycle during a shift: outputs go to 0 before the next edge, and the first post-release SHIFT_FWD gives fill=1.
